uart_rx_buffered: RTL and testbench

//  Synthesizable, parametrised UART receiver with receive FIFO: next-generation successor to the fixed 8N1 bench UART.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_rx_buffered_fifo.sv | 49 ++++
 rtl/uart_rx_buffered.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared state encoding and parameter legality helpers for the buffered UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    function automatic bit data_bits_ok(input int n);
        return (n >= 5) && (n <= 8);
    endfunction

    function automatic bit stop_bits_ok(input int n);
        return (n == 1) || (n == 2);
    endfunction

    function automatic bit parity_cfg_ok(input int en, input int odd);
        return (en inside {0, 1}) && (odd inside {0, 1});
    endfunction

    function automatic bit fifo_depth_ok(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_rx_buffered_fifo.sv
// Receive FIFO: register array with wrap-around pointers one bit wider than the index.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (r_wr == r_rd);
    assign full_o    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    assign rdata_o = empty_o ? '0 : r_mem[r_rd[AW-1:0]];
    assign level_o = r_wr - r_rd;

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with runtime baud divisor, optional parity, 1/2 stop bits,
// start-bit glitch rejection, sticky error flags and a receive FIFO.
module uart_rx_buffered
    import uart_rx_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_en_i,
    input  logic [DIV_WIDTH-1:0]          cfg_div_i,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          rdata_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overrun_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    input  logic                          err_clr_i
);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (!data_bits_ok(DATA_BITS)) begin : g_bad_data
        $error("uart_rx_buffered: DATA_BITS must be 5..8");
    end
    if (!stop_bits_ok(STOP_BITS)) begin : g_bad_stop
        $error("uart_rx_buffered: STOP_BITS must be 1 or 2");
    end
    if (!parity_cfg_ok(PARITY_EN, PARITY_ODD)) begin : g_bad_par
        $error("uart_rx_buffered: PARITY_EN/PARITY_ODD must be 0 or 1");
    end
    if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_fifo
        $error("uart_rx_buffered: FIFO_DEPTH must be a power of 2, >= 2");
    end

    rx_state_e               r_state;
    logic                    r_rx_meta;
    logic                    r_rxs;
    logic                    r_rxs_d;
    logic [DIV_WIDTH-1:0]    r_timer;
    logic [DIV_WIDTH-1:0]    r_div;
    logic [BW-1:0]           r_bit_cnt;
    logic [DATA_BITS-1:0]    r_shift;
    logic                    r_perr;

    logic                    w_fall;
    logic                    w_expire;
    logic [DIV_WIDTH-1:0]    w_half;
    logic                    w_stop_ok;
    logic                    w_frame_set;
    logic                    w_perr_set;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_ovr_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
        end
    end

    assign w_fall   = r_rxs_d & ~r_rxs;
    assign w_expire = (r_timer == '0);
    // (cfg_div_i+1)>>1 without widening past DIV_WIDTH
    assign w_half   = (cfg_div_i >> 1) + DIV_WIDTH'(cfg_div_i[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
        end else if (!rx_en_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_div   <= cfg_div_i;
                        r_timer <= w_half;
                    end
                end
                ST_START: begin
                    if (w_expire) begin
                        r_timer   <= r_div;
                        r_bit_cnt <= '0;
                        r_perr    <= 1'b0;
                        r_state   <= r_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        r_timer <= r_timer - DIV_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (w_expire) begin
                        r_timer <= r_div;
                        r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == LAST_DATA) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end else begin
                        r_timer <= r_timer - DIV_WIDTH'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_expire) begin
                        r_timer <= r_div;
                        r_perr  <= ((^r_shift) ^ r_rxs) != 1'(PARITY_ODD);
                        r_state <= ST_STOP;
                    end else begin
                        r_timer <= r_timer - DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (w_expire) begin
                        r_timer <= r_div;
                        if (!r_rxs) begin
                            r_state <= ST_BREAK;
                        end else if (r_bit_cnt == LAST_STOP) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end else begin
                        r_timer <= r_timer - DIV_WIDTH'(1);
                    end
                end
                ST_BREAK: begin
                    // Line may stay low for a long break; only one frame error per event.
                    if (r_rxs) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_stop_ok   = rx_en_i & (r_state == ST_STOP) & w_expire & r_rxs & (r_bit_cnt == LAST_STOP);
    assign w_frame_set = rx_en_i & (r_state == ST_STOP) & w_expire & ~r_rxs;
    assign w_perr_set  = w_stop_ok & r_perr;
    assign w_push      = w_stop_ok & ~r_perr;
    assign w_pop       = rvalid_o & rready_i;
    assign w_ovr_set   = w_push & w_full & ~w_pop;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i (r_shift),
        .pop_i   (w_pop),
        .rdata_o (rdata_o),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

    assign rvalid_o = ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_o    <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            if (w_ovr_set)       overrun_o <= 1'b1;
            else if (err_clr_i)  overrun_o <= 1'b0;
            if (w_perr_set)      parity_err_o <= 1'b1;
            else if (err_clr_i)  parity_err_o <= 1'b0;
            if (w_frame_set)     frame_err_o <= 1'b1;
            else if (err_clr_i)  frame_err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: 8N1 depth-4 instance (a) and 8E1 depth-8 instance (b),
// vector table, directed corner sequences and a randomized run against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en;
    logic [15:0] cfg_div;
    logic        err_clr;
    logic        rx_a, rx_b;
    logic        rready_a, rready_b;

    logic [7:0]  a_rdata, b_rdata;
    logic        a_rvalid, b_rvalid;
    logic [2:0]  a_level;
    logic [3:0]  b_level;
    logic        a_ovr, a_perr, a_ferr;
    logic        b_ovr, b_perr, b_ferr;

    int checks = 0;
    int failures = 0;

    always #20 clk = ~clk;

    uart_rx_buffered #(.DIV_WIDTH(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .rx_en_i(rx_en), .cfg_div_i(cfg_div), .rx_i(rx_a),
        .rdata_o(a_rdata), .rvalid_o(a_rvalid), .rready_i(rready_a), .level_o(a_level),
        .overrun_o(a_ovr), .parity_err_o(a_perr), .frame_err_o(a_ferr), .err_clr_i(err_clr));

    uart_rx_buffered #(.DIV_WIDTH(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                       .STOP_BITS(1), .FIFO_DEPTH(8)) u_b (
        .clk(clk), .rst(rst), .rx_en_i(rx_en), .cfg_div_i(cfg_div), .rx_i(rx_b),
        .rdata_o(b_rdata), .rvalid_o(b_rvalid), .rready_i(rready_b), .level_o(b_level),
        .overrun_o(b_ovr), .parity_err_o(b_perr), .frame_err_o(b_ferr), .err_clr_i(err_clr));

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_rdata;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [7];

    logic [7:0] mq [$];
    logic m_ovr, m_perr, m_ferr;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop_v, input int div);
        drive(which, 1'b0);
        tick(div + 1);
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]);
            tick(div + 1);
        end
        if (has_par) begin
            drive(which, par);
            tick(div + 1);
        end
        drive(which, stop_v);
        tick(div + 1);
        drive(which, 1'b1);
    endtask

    task automatic pop(input int which);
        if (which == 0) rready_a = 1'b1; else rready_b = 1'b1;
        tick(1);
        rready_a = 1'b0;
        rready_b = 1'b0;
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        int lat;
        logic [7:0] d;
        bit bad_p, bad_s;
        int div, n;

        // data, parity bit, stop bit, valid, rdata, perr, ferr (8E1 instance)
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

        rst = 1'b1; rx_en = 1'b1; cfg_div = 16'd31; err_clr = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1; rready_a = 1'b0; rready_b = 1'b0;
        tick(3);
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 0);
        chk("rst_a_rdata", {24'd0, a_rdata}, 0);
        chk("rst_a_level", {29'd0, a_level}, 0);
        chk("rst_a_flags", {29'd0, a_ovr, a_perr, a_ferr}, 0);
        chk("rst_b_level", {28'd0, b_level}, 0);
        chk("rst_b_flags", {29'd0, b_ovr, b_perr, b_ferr}, 0);
        rst = 1'b0;
        tick(5);

        // vector table on the even-parity instance
        for (int v = 0; v < 7; v++) begin
            clear_flags();
            send_frame(1, vecs[v].data, 1'b1, vecs[v].par, vecs[v].stop, 31);
            tick(4);
            chk($sformatf("vec%0d_rvalid", v), {31'd0, b_rvalid}, {31'd0, vecs[v].exp_valid});
            chk($sformatf("vec%0d_rdata", v), {24'd0, b_rdata}, {24'd0, vecs[v].exp_rdata});
            chk($sformatf("vec%0d_perr", v), {31'd0, b_perr}, {31'd0, vecs[v].exp_perr});
            chk($sformatf("vec%0d_ferr", v), {31'd0, b_ferr}, {31'd0, vecs[v].exp_ferr});
            if (vecs[v].exp_valid) pop(1);
            chk($sformatf("vec%0d_level_after", v), {28'd0, b_level}, 0);
        end
        clear_flags();

        // 8N1 0x65 with latency from start edge
        lat = 0;
        fork
            send_frame(0, 8'h65, 1'b0, 1'b0, 1'b1, 31);
            begin
                while (!a_rvalid && lat < 400) begin
                    tick(1);
                    lat++;
                end
            end
        join
        checks++;
        if (lat < 303 || lat > 313) begin
            failures++;
            $display("FAIL t1_latency: got %0d cycles expected 303..313", lat);
        end
        tick(4);
        chk("t1_rdata", {24'd0, a_rdata}, 32'h65);
        chk("t1_flags", {29'd0, a_ovr, a_perr, a_ferr}, 0);
        pop(0);

        // overrun with depth 4
        for (int c = 1; c <= 5; c++) begin
            send_frame(0, 8'(c), 1'b0, 1'b0, 1'b1, 31);
            tick(4);
        end
        chk("t3_level", {29'd0, a_level}, 4);
        chk("t3_overrun", {31'd0, a_ovr}, 1);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("t3_pop%0d", c), {24'd0, a_rdata}, c);
            pop(0);
        end
        chk("t3_empty", {31'd0, a_rvalid}, 0);

        // frame error then long break
        send_frame(0, 8'hA7, 1'b0, 1'b0, 1'b0, 31);
        drive(0, 1'b0);
        tick(3 * 10 * 32);
        chk("t4_ferr", {31'd0, a_ferr}, 1);
        chk("t4_ovr_sticky", {31'd0, a_ovr}, 1);
        chk("t4_level", {29'd0, a_level}, 0);
        clear_flags();
        chk("t4_cleared", {29'd0, a_ovr, a_perr, a_ferr}, 0);
        tick(100);
        drive(0, 1'b1);
        tick(20);
        chk("t4_no_second_ferr", {31'd0, a_ferr}, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 31);
        tick(4);
        chk("t4_next_rdata", {24'd0, a_rdata}, 32'h3C);
        chk("t4_next_flags", {29'd0, a_ovr, a_perr, a_ferr}, 0);
        pop(0);

        // short glitch on idle line
        drive(0, 1'b0);
        tick(10);
        drive(0, 1'b1);
        tick(400);
        chk("t5_level", {29'd0, a_level}, 0);
        chk("t5_flags", {29'd0, a_ovr, a_perr, a_ferr}, 0);

        // enable dropped mid-char
        drive(0, 1'b0); tick(32);
        drive(0, 1'b1); tick(32);
        drive(0, 1'b0); tick(16);
        rx_en = 1'b0; tick(3);
        drive(0, 1'b1); tick(400);
        rx_en = 1'b1; tick(10);
        chk("t6_en_level", {29'd0, a_level}, 0);
        chk("t6_en_flags", {29'd0, a_ovr, a_perr, a_ferr}, 0);

        // reset pulsed mid-char
        drive(0, 1'b0); tick(32);
        drive(0, 1'b1); tick(20);
        rst = 1'b1; tick(2);
        chk("t6_rst_level", {29'd0, a_level}, 0);
        chk("t6_rst_rvalid", {31'd0, a_rvalid}, 0);
        rst = 1'b0;
        tick(400);
        cfg_div = 16'd15;
        tick(2);
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1, 15);
        tick(4);
        chk("t6_rvalid", {31'd0, a_rvalid}, 1);
        chk("t6_rdata", {24'd0, a_rdata}, 32'h7E);
        chk("t6_flags", {29'd0, a_ovr, a_perr, a_ferr}, 0);
        pop(0);

        // randomized frames on the parity instance vs frame-level model
        mq.delete();
        m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        clear_flags();
        for (int f = 0; f < 30; f++) begin
            d     = 8'($urandom);
            bad_p = ($urandom_range(0, 4) == 0);
            bad_s = ($urandom_range(0, 7) == 0);
            div   = $urandom_range(5, 31);
            cfg_div = 16'(div);
            tick(2);
            send_frame(1, d, 1'b1, (^d) ^ bad_p, ~bad_s, div);
            tick(4);
            if (bad_s)               m_ferr = 1'b1;
            else if (bad_p)          m_perr = 1'b1;
            else if (mq.size() == 8) m_ovr = 1'b1;
            else                     mq.push_back(d);
            n = $urandom_range(0, mq.size());
            for (int k = 0; k < n; k++) begin
                chk($sformatf("rnd%0d_rvalid", f), {31'd0, b_rvalid}, 1);
                chk($sformatf("rnd%0d_rdata", f), {24'd0, b_rdata}, {24'd0, mq[0]});
                pop(1);
                void'(mq.pop_front());
            end
            chk($sformatf("rnd%0d_level", f), {28'd0, b_level}, mq.size());
            chk($sformatf("rnd%0d_flags", f), {29'd0, b_ovr, b_perr, b_ferr},
                {29'd0, m_ovr, m_perr, m_ferr});
            if ($urandom_range(0, 5) == 0) begin
                clear_flags();
                m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
            end
        end
        while (mq.size() > 0) begin
            chk("drain_rdata", {24'd0, b_rdata}, {24'd0, mq[0]});
            pop(1);
            void'(mq.pop_front());
        end
        chk("drain_level", {28'd0, b_level}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
